// File: rtl/core_pkg.sv
// core_pkg: shared definitions for the RV32I multi-cycle core.
//   - RV32I base opcode constants (instr[6:0])
//   - state_t  : control FSM states
//   - pc_sel_t : next-PC mux select encoding
//   - is_base_opcode(): true for the eleven RV32I base opcodes
package core_pkg;

  localparam logic [6:0] OP_IMM   = 7'h13;
  localparam logic [6:0] OP       = 7'h33;
  localparam logic [6:0] LUI      = 7'h37;
  localparam logic [6:0] AUIPC    = 7'h17;
  localparam logic [6:0] JAL      = 7'h6F;
  localparam logic [6:0] JALR     = 7'h67;
  localparam logic [6:0] BRANCH   = 7'h63;
  localparam logic [6:0] LOAD     = 7'h03;
  localparam logic [6:0] STORE    = 7'h23;
  localparam logic [6:0] MISC_MEM = 7'h0F;
  localparam logic [6:0] SYSTEM   = 7'h73;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5,
    ERR    = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    PC_PLUS4 = 2'b00,
    PC_REL   = 2'b01,
    PC_REG   = 2'b10
  } pc_sel_t;

  function automatic logic is_base_opcode(input logic [6:0] op);
    return op inside {OP_IMM, OP, LUI, AUIPC, JAL, JALR,
                      BRANCH, LOAD, STORE, MISC_MEM, SYSTEM};
  endfunction

endpackage

// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle control FSM for the RV32I core. Sequences
// fetch / decode / execute / memory / write-back around a shared single-port
// memory and drives the IR, PC, register-file and memory strobes.
//
// Ports:
//   clk           core clock, rising edge
//   rst_n         asynchronous active-low reset
//   opcode[6:0]   opcode field of the latched instruction register
//   branch_taken  ALU compare result for the current BRANCH
//   mem_ready     memory completes the presented access this cycle
//   mem_req       memory access request
//   mem_we        memory write strobe (STORE data phase)
//   mem_sel_data  address mux: 0 = PC, 1 = ALU result
//   ir_we         latch fetched word into the IR
//   pc_we         update PC this cycle
//   pc_sel[1:0]   next-PC mux (pc_sel_t)
//   rf_we         register-file write enable
//   halted        SYSTEM opcode reached (sticky until reset)
//   error         illegal opcode or memory timeout (sticky until reset)
//   retired[31:0] retired-instruction count, wraps
//
// Build option: define MEM_TIMEOUT_EN to abort a memory access that waits
// TIMEOUT consecutive cycles for mem_ready; the FSM then enters ERR.
//
// state  | meaning
// FETCH  | request instruction word at PC, latch into IR on mem_ready
// DECODE | register read; SYSTEM -> HALT, non-base opcode -> ERR
// EXEC   | ALU cycle; BRANCH / MISC_MEM retire here
// MEM    | data access at ALU address; STORE retires on mem_ready
// WB     | register write-back and PC update; retire
// HALT   | terminal, all strobes low
// ERR    | terminal, all strobes low
module core_sequencer
  import core_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  opcode,
  input  logic        branch_taken,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_sel_data,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        rf_we,
  output logic        halted,
  output logic        error,
  output logic [31:0] retired
);

  state_t  state;
  state_t  state_nxt;
  pc_sel_t pc_sel_c;
  logic    timed_out;

  // Memory-phase states; derived from the state register rather than from
  // mem_req so the timeout path does not loop through the output logic.
  logic in_mem_phase;
  assign in_mem_phase = (state == FETCH) || (state == MEM);

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(TIMEOUT - 1);

  logic [WAIT_W-1:0] wait_left;
  logic              mem_wait;

  // Down-counter of remaining wait cycles; the cycle that finds it at zero
  // while still waiting is the TIMEOUT-th consecutive wait cycle.
  assign mem_wait  = in_mem_phase && !mem_ready;
  assign timed_out = mem_wait && (wait_left == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_left <= WAIT_LOAD;
    end else if (mem_wait && !timed_out) begin
      wait_left <= wait_left - 1'b1;
    end else begin
      wait_left <= WAIT_LOAD;
    end
  end
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT);
  assign timed_out      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_sel_data = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_sel_c     = PC_PLUS4;
    rf_we        = 1'b0;

    unique case (state)
      FETCH: begin
        mem_req = 1'b1;
        if (timed_out) begin
          state_nxt = ERR;
        end else if (mem_ready) begin
          ir_we     = 1'b1;
          state_nxt = DECODE;
        end
      end

      DECODE: begin
        if (opcode == SYSTEM) begin
          state_nxt = HALT;
        end else if (!is_base_opcode(opcode)) begin
          state_nxt = ERR;
        end else begin
          state_nxt = EXEC;
        end
      end

      EXEC: begin
        case (opcode)
          LOAD, STORE: state_nxt = MEM;
          BRANCH: begin
            pc_we     = 1'b1;
            pc_sel_c  = branch_taken ? PC_REL : PC_PLUS4;
            state_nxt = FETCH;
          end
          MISC_MEM: begin
            pc_we     = 1'b1;
            state_nxt = FETCH;
          end
          default: state_nxt = WB;
        endcase
      end

      MEM: begin
        mem_req      = 1'b1;
        mem_sel_data = 1'b1;
        mem_we       = (opcode == STORE);
        if (timed_out) begin
          state_nxt = ERR;
        end else if (mem_ready) begin
          if (opcode == STORE) begin
            pc_we     = 1'b1;
            state_nxt = FETCH;
          end else begin
            state_nxt = WB;
          end
        end
      end

      WB: begin
        rf_we = 1'b1;
        pc_we = 1'b1;
        if (opcode == JAL) begin
          pc_sel_c = PC_REL;
        end else if (opcode == JALR) begin
          pc_sel_c = PC_REG;
        end
        state_nxt = FETCH;
      end

      HALT: state_nxt = HALT;
      ERR:  state_nxt = ERR;

      default: state_nxt = ERR;
    endcase

    // Strobes drop the moment reset asserts, even mid-access, so an
    // in-flight memory request is abandoned without waiting for a clock.
    if (!rst_n) begin
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_sel_data = 1'b0;
      ir_we        = 1'b0;
      pc_we        = 1'b0;
      pc_sel_c     = PC_PLUS4;
      rf_we        = 1'b0;
    end
  end

  assign pc_sel = pc_sel_c;
  assign halted = (state == HALT);
  assign error  = (state == ERR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired <= '0;
    end else if (pc_we) begin
      retired <= retired + 32'd1;
    end
  end

endmodule

// File: tb/tb_core_sequencer.sv
// Testbench for core_sequencer. The bench acts as memory and instruction
// register; for each instruction it derives the expected per-cycle strobe
// pattern from the instruction's class and the memory wait counts it chose.
module tb_core_sequencer;

  localparam int TO = 16;

  localparam logic [6:0] O_OP_IMM = 7'h13, O_OP     = 7'h33, O_LUI    = 7'h37;
  localparam logic [6:0] O_AUIPC  = 7'h17, O_JAL    = 7'h6F, O_JALR   = 7'h67;
  localparam logic [6:0] O_BRANCH = 7'h63, O_LOAD   = 7'h03, O_STORE  = 7'h23;
  localparam logic [6:0] O_MISC   = 7'h0F, O_SYSTEM = 7'h73;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  opcode;
  logic        branch_taken;
  logic        mem_ready;
  logic        mem_req, mem_we, mem_sel_data, ir_we, pc_we, rf_we, halted, error;
  logic [1:0]  pc_sel;
  logic [31:0] retired;

  core_sequencer #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .mem_sel_data(mem_sel_data), .ir_we(ir_we), .pc_we(pc_we),
    .pc_sel(pc_sel), .rf_we(rf_we), .halted(halted), .error(error),
    .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       req, we, sel, ir, pcwe;
    logic [1:0] pcsel;
    logic       rf, hlt, err;
  } vec_t;

  int total = 0;
  int bad   = 0;

  int          cyc, ir_cyc, pcwe_cyc, rfwe_cyc, rfwe_cnt, data_req_cnt, err_cyc;
  logic [1:0]  pcsel_at_pcwe;
  logic [31:0] model_retired;
  bit          model_halt, model_err;
  logic [6:0]  pend_opc;
  logic [6:0]  pool [10];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at t=%0t", name, got, want, $time);
    end
  endtask

  function automatic vec_t mk(input bit req, input bit we, input bit sel, input bit ir,
                              input bit pcwe, input logic [1:0] pcsel, input bit rf);
    vec_t v;
    v = {req, we, sel, ir, pcwe, pcsel, rf, 1'b0, 1'b0};
    return v;
  endfunction

  function automatic vec_t sample();
    vec_t v;
    v = {mem_req, mem_we, mem_sel_data, ir_we, pc_we, pc_sel, rf_we, halted, error};
    return v;
  endfunction

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic bit legal(input logic [6:0] o);
    return o inside {O_OP_IMM, O_OP, O_LUI, O_AUIPC, O_JAL, O_JALR,
                     O_BRANCH, O_LOAD, O_STORE, O_MISC, O_SYSTEM};
  endfunction

  // One clock cycle: drive mem_ready, compare at the falling edge, then
  // advance the model at the rising edge.
  task automatic step(input bit rdy, input vec_t e);
    vec_t got;
    cyc++;
    mem_ready = rdy;
    e.hlt = model_halt;
    e.err = model_err;
    @(negedge clk);
    got = sample();
    check("outputs", 32'(got), 32'(e));
    check("retired", retired, model_retired);
    if (ir_we && ir_cyc == 0) ir_cyc = cyc;
    if (pc_we) begin
      pcwe_cyc      = cyc;
      pcsel_at_pcwe = pc_sel;
    end
    if (rf_we) begin
      rfwe_cyc = cyc;
      rfwe_cnt++;
    end
    if (mem_req && mem_sel_data) data_req_cnt++;
    if (error && err_cyc == 0) err_cyc = cyc;
    @(posedge clk);
    if (e.pcwe) model_retired = model_retired + 32'd1;
    #1;
    if (e.ir) opcode = pend_opc;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(rb(), mk(0, 0, 0, 0, 0, 2'b00, 0));
  endtask

  // A memory access: `waits` cycles without mem_ready, then the ready cycle.
  task automatic mem_access(input bit data, input bit we, input int waits,
                            input bit done_pcwe, output bit to);
    int n;
    to = 1'b0;
    n  = waits;
`ifdef MEM_TIMEOUT_EN
    if (waits >= TO) begin
      n  = TO;
      to = 1'b1;
    end
`endif
    for (int i = 0; i < n; i++) step(1'b0, mk(1, we, data, 0, 0, 2'b00, 0));
    if (to) model_err = 1'b1;
    else    step(1'b1, mk(1, we, data, !data, done_pcwe, 2'b00, 0));
  endtask

  task automatic clear_obs();
    cyc = 0; ir_cyc = 0; pcwe_cyc = 0; rfwe_cyc = 0; rfwe_cnt = 0;
    data_req_cnt = 0; err_cyc = 0; pcsel_at_pcwe = 2'b11;
  endtask

  task automatic run_instr(input logic [6:0] opc, input int wf, input int wd, input bit tk);
    bit to;
    clear_obs();
    pend_opc     = opc;
    branch_taken = tk;
    mem_access(1'b0, 1'b0, wf, 1'b0, to);
    if (to) begin
      idle(3);
      return;
    end
    step(rb(), mk(0, 0, 0, 0, 0, 2'b00, 0));
    if (opc == O_SYSTEM) begin
      model_halt = 1'b1;
      idle(4);
      return;
    end
    if (!legal(opc)) begin
      model_err = 1'b1;
      idle(4);
      return;
    end
    if (opc == O_BRANCH) begin
      step(rb(), mk(0, 0, 0, 0, 1, tk ? 2'b01 : 2'b00, 0));
      return;
    end
    if (opc == O_MISC) begin
      step(rb(), mk(0, 0, 0, 0, 1, 2'b00, 0));
      return;
    end
    step(rb(), mk(0, 0, 0, 0, 0, 2'b00, 0));
    if (opc == O_LOAD || opc == O_STORE) begin
      mem_access(1'b1, opc == O_STORE, wd, opc == O_STORE, to);
      if (to) begin
        idle(3);
        return;
      end
      if (opc == O_STORE) return;
    end
    step(rb(), mk(0, 0, 0, 0, 1,
                  (opc == O_JAL) ? 2'b01 : (opc == O_JALR) ? 2'b10 : 2'b00, 1));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("reset_outputs", 32'(sample()), 32'h0);
    check("reset_retired", retired, 32'h0);
    model_retired = 32'h0;
    model_halt    = 1'b0;
    model_err     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit to;
    pool = '{O_OP_IMM, O_OP, O_LUI, O_AUIPC, O_JAL, O_JALR,
             O_BRANCH, O_LOAD, O_STORE, O_MISC};
    mem_ready = 1'b0; opcode = 7'h00; branch_taken = 1'b0;
    model_retired = 32'h0; model_halt = 1'b0; model_err = 1'b0;
    do_reset();

    // ADDI x1, x0, 5 with zero-wait memory
    run_instr(O_OP_IMM, 0, 0, 1'b0);
    check("addi_ir_cyc", 32'(ir_cyc), 32'd1);
    check("addi_pcwe_cyc", 32'(pcwe_cyc), 32'd4);
    check("addi_rfwe_cyc", 32'(rfwe_cyc), 32'd4);
    check("addi_pc_sel", 32'(pcsel_at_pcwe), 32'd0);
    check("addi_retired", retired, 32'd1);

    // LW with two data wait cycles
    run_instr(O_LOAD, 0, 2, 1'b0);
    check("lw_total_cyc", 32'(pcwe_cyc), 32'd7);
    check("lw_data_req_cyc", 32'(data_req_cnt), 32'd3);
    check("lw_rfwe_cnt", 32'(rfwe_cnt), 32'd1);

    // BEQ taken then not taken
    run_instr(O_BRANCH, 0, 0, 1'b1);
    check("beq_t_cyc", 32'(pcwe_cyc), 32'd3);
    check("beq_t_sel", 32'(pcsel_at_pcwe), 32'd1);
    check("beq_t_rfwe", 32'(rfwe_cnt), 32'd0);
    run_instr(O_BRANCH, 0, 0, 1'b0);
    check("beq_n_cyc", 32'(pcwe_cyc), 32'd3);
    check("beq_n_sel", 32'(pcsel_at_pcwe), 32'd0);

    // JALR
    run_instr(O_JALR, 0, 0, 1'b0);
    check("jalr_rfwe_cyc", 32'(rfwe_cyc), 32'd4);
    check("jalr_sel", 32'(pcsel_at_pcwe), 32'd2);
    check("retired_5", retired, 32'd5);

    // Randomized instruction mix with random memory waits
    for (int n = 0; n < 200; n++) begin
      run_instr(pool[$urandom_range(0, 9)], $urandom_range(0, 3),
                $urandom_range(0, 3), rb());
    end

    // Reset pulse in the middle of a LOAD data wait
    clear_obs();
    pend_opc = O_LOAD;
    mem_access(1'b0, 1'b0, 1, 1'b0, to);
    step(rb(), mk(0, 0, 0, 0, 0, 2'b00, 0));
    step(rb(), mk(0, 0, 0, 0, 0, 2'b00, 0));
    step(1'b0, mk(1, 0, 1, 0, 0, 2'b00, 0));
    step(1'b0, mk(1, 0, 1, 0, 0, 2'b00, 0));
    do_reset();
    check("retired_after_reset", retired, 32'd0);
    run_instr(O_STORE, 1, 1, 1'b0);
    check("store_total_cyc", 32'(pcwe_cyc), 32'd6);
    check("retired_after_store", retired, 32'd1);

    // Illegal opcode
    run_instr(7'h7F, 0, 0, 1'b0);
    check("illegal_error", 32'(error), 32'd1);
    check("illegal_err_cyc", 32'(err_cyc), 32'd3);
    do_reset();

`ifdef MEM_TIMEOUT_EN
    // Fetch that never completes
    run_instr(O_OP_IMM, 40, 0, 1'b0);
    check("timeout_err_cyc", 32'(err_cyc), 32'd17);
    check("timeout_error", 32'(error), 32'd1);
    do_reset();
`endif

    // ECALL
    run_instr(O_OP, 1, 0, 1'b0);
    run_instr(O_SYSTEM, 0, 0, 1'b0);
    check("ecall_halted", 32'(halted), 32'd1);
    check("ecall_retired", retired, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
